// File: rtl/blur_line_scheduler_if.sv
// rtl/blur_line_scheduler_if.sv - pixel handshake and line-buffer control bundle for blur_line_scheduler
//
// master: camera/control side (drives frame_start, in_valid, kernel_sel)
// slave : scheduler side (drives in_ready, blur_toggle, buf_addr, buf_wren,
//         row, col, out_valid, frame_busy, frame_done, overrun)
interface blur_line_scheduler_if #(
    parameter int ADDR_W = 13
);
    logic              frame_start;
    logic              in_valid;
    logic              in_ready;
    logic              kernel_sel;
    logic              blur_toggle;
    logic [ADDR_W-1:0] buf_addr;
    logic              buf_wren;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic              out_valid;
    logic              frame_busy;
    logic              frame_done;
    logic              overrun;

    modport master (
        output frame_start, in_valid, kernel_sel,
        input  in_ready, blur_toggle, buf_addr, buf_wren, row, col,
               out_valid, frame_busy, frame_done, overrun
    );

    modport slave (
        input  frame_start, in_valid, kernel_sel,
        output in_ready, blur_toggle, buf_addr, buf_wren, row, col,
               out_valid, frame_busy, frame_done, overrun
    );
endinterface

// File: rtl/blur_line_scheduler.sv
// rtl/blur_line_scheduler.sv - paces camera pixels through the convolve / write-back blur pipeline
//
// clk, rst_n : clock, asynchronous active-low reset
// bus        : blur_line_scheduler_if.slave (pixel handshake, kernel select,
//              line-buffer address/write enable, window-valid flag, frame status)
module blur_line_scheduler #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 13,
    parameter int H_LAT  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    blur_line_scheduler_if.slave bus
);

    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] COL_MIN    = ADDR_W'(H_LAT);
    localparam logic [ADDR_W-1:0] ROW_MIN_5  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ROW_MIN_11 = ADDR_W'(10);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_COMMIT,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic              toggle_q, toggle_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic restart;
    logic window_full;

    // A frame_start outside IDLE abandons the current frame and begins a new one.
    assign restart = bus.frame_start && (state_q != ST_IDLE);

    // Vertical window needs K-1 prior lines, horizontal needs H_LAT prior pixels.
    assign window_full = (row_q >= (toggle_q ? ROW_MIN_11 : ROW_MIN_5)) && (col_q >= COL_MIN);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        toggle_d  = toggle_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    toggle_d = bus.kernel_sel;
                    row_d    = '0;
                    col_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (bus.in_valid) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                    // busy drops together with the frame_done pulse
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                row_d   = '0;
                col_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (restart) begin
            overrun_d = 1'b1;
            row_d     = '0;
            col_d     = '0;
            toggle_d  = bus.kernel_sel;
            busy_d    = 1'b1;
            state_d   = ST_ACCEPT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            toggle_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            toggle_q  <= toggle_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    // Strobes decode straight from the state register; a restart in the same
    // cycle masks the write-back and done pulse of the abandoned frame.
    assign bus.in_ready    = (state_q == ST_ACCEPT);
    assign bus.buf_wren    = (state_q == ST_COMMIT) && !bus.frame_start;
    assign bus.out_valid   = (state_q == ST_COMMIT) && !bus.frame_start && window_full;
    assign bus.frame_done  = (state_q == ST_DONE) && !bus.frame_start;
    assign bus.buf_addr    = col_q;
    assign bus.row         = row_q;
    assign bus.col         = col_q;
    assign bus.blur_toggle = toggle_q;
    assign bus.frame_busy  = busy_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_blur_line_scheduler.sv
// tb/tb_blur_line_scheduler.sv - self-checking bench for blur_line_scheduler
module tb_blur_line_scheduler;

    localparam int W  = 8;
    localparam int H  = 12;
    localparam int HL = 2;
    localparam int AW = 13;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    blur_line_scheduler_if #(.ADDR_W(AW)) bus ();

    blur_line_scheduler #(
        .WIDTH (W),
        .HEIGHT(H),
        .ADDR_W(AW),
        .H_LAT (HL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame position as a linear pixel index plus a phase.
    // phase 0 idle, 1 waiting for pixel, 2 writing back, 3 end of frame
    int m_mode = 0;
    int m_pix  = 0;
    bit m_tog  = 1'b0;
    bit m_busy = 1'b0;
    bit m_ovr  = 1'b0;

    int f_wren, f_ov, f_done;

    typedef struct {
        bit ks;
        int stall_pix;
        int stall_len;
        int flip;
        int rmode;   // 0 none, 1 restart while waiting at rpix, 2 while writing rpix, 3 at end of frame
        int rpix;
        bit rnd;
        int exp_wren;
        int exp_ov;
        bit exp_tog;
        bit exp_ovr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [45:0] actual();
        return {bus.in_ready, bus.buf_wren, bus.out_valid, bus.frame_done, bus.frame_busy,
                bus.overrun, bus.blur_toggle, bus.row, bus.col, bus.buf_addr};
    endfunction

    function automatic logic [45:0] expected(input bit fs);
        logic [AW-1:0] r;
        logic [AW-1:0] c;
        logic          wren;
        logic          ov;
        r    = AW'(m_pix / W);
        c    = AW'(m_pix % W);
        wren = (m_mode == 2) && !fs;
        ov   = wren && ((m_pix / W) >= (m_tog ? 10 : 4)) && ((m_pix % W) >= HL);
        return {(m_mode == 1), wren, ov, ((m_mode == 3) && !fs), m_busy, m_ovr, m_tog, r, c, c};
    endfunction

    task automatic model_adv(input bit fs, input bit iv, input bit ks);
        if (fs) begin
            if (m_mode != 0) m_ovr = 1'b1;
            m_pix  = 0;
            m_tog  = ks;
            m_busy = 1'b1;
            m_mode = 1;
        end else begin
            case (m_mode)
                1: if (iv) m_mode = 2;
                2: begin
                    m_pix++;
                    if (m_pix == W * H) begin
                        m_mode = 3;
                        m_busy = 1'b0;
                    end else begin
                        m_mode = 1;
                    end
                end
                3: begin
                    m_mode = 0;
                    m_pix  = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit fs, input bit iv, input bit ks);
        @(negedge clk);
        bus.frame_start = fs;
        bus.in_valid    = iv;
        bus.kernel_sel  = ks;
        #1;
        chk("cycle", 64'(actual()), 64'(expected(fs)));
        if (bus.buf_wren)   f_wren++;
        if (bus.out_valid)  f_ov++;
        if (bus.frame_done) f_done++;
        model_adv(fs, iv, ks);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        bit iv, ks, fs, stall_now, restarted;
        int stalled;
        f_wren = 0;
        f_ov = 0;
        f_done = 0;
        restarted = 1'b0;
        stalled = 0;
        step(1'b1, 1'b0, v.ks);
        for (int cyc = 0; cyc < 3000 && f_done == 0; cyc++) begin
            iv = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ks = (v.flip >= 0 && m_pix >= v.flip) ? !v.ks : v.ks;
            fs = 1'b0;
            stall_now = 1'b0;
            if (!restarted) begin
                case (v.rmode)
                    1: if (m_mode == 1 && m_pix == v.rpix) fs = 1'b1;
                    2: if (m_mode == 2 && m_pix == v.rpix) fs = 1'b1;
                    3: if (m_mode == 3) fs = 1'b1;
                    default: ;
                endcase
            end
            if (fs) restarted = 1'b1;
            if (v.stall_pix >= 0 && m_mode == 1 && m_pix == v.stall_pix && stalled < v.stall_len) begin
                iv = 1'b0;
                stalled++;
                stall_now = 1'b1;
            end
            step(fs, iv, ks);
            if (stall_now) begin
                chk("stall_ready", 64'(bus.in_ready), 64'd1);
                chk("stall_addr", 64'(bus.buf_addr), 64'(v.stall_pix % W));
                chk("stall_wren", 64'(bus.buf_wren), 64'd0);
            end
        end
        chk($sformatf("v%0d_wren", idx), 64'(f_wren), 64'(v.exp_wren));
        chk($sformatf("v%0d_out_valid", idx), 64'(f_ov), 64'(v.exp_ov));
        chk($sformatf("v%0d_done", idx), 64'(f_done), 64'd1);
        chk($sformatf("v%0d_toggle", idx), 64'(bus.blur_toggle), 64'(v.exp_tog));
        chk($sformatf("v%0d_overrun", idx), 64'(bus.overrun), 64'(v.exp_ovr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        vec_t post;

        vecs[0] = '{0, -1, 0, -1, 0, 0,  0,  96, 48, 0, 0};
        vecs[1] = '{1, -1, 0, -1, 0, 0,  0,  96, 12, 1, 0};
        vecs[2] = '{0, 19, 5, -1, 0, 0,  0,  96, 48, 0, 0};
        vecs[3] = '{0, -1, 0, 48, 0, 0,  0,  96, 48, 0, 0};
        vecs[4] = '{1, -1, 0, -1, 0, 0,  0,  96, 12, 1, 0};
        vecs[5] = '{0, -1, 0, -1, 1, 29, 0, 125, 48, 0, 1};
        vecs[6] = '{0, -1, 0, -1, 2, 40, 0, 136, 54, 0, 1};
        vecs[7] = '{1, -1, 0, -1, 3, 0,  0, 192, 24, 1, 1};
        vecs[8] = '{1, -1, 0, -1, 0, 0,  1,  96, 12, 1, 1};
        vecs[9] = '{0, -1, 0, -1, 0, 0,  1,  96, 48, 0, 1};

        rst_n = 1'b0;
        bus.frame_start = 1'b0;
        bus.in_valid    = 1'b0;
        bus.kernel_sel  = 1'b1;
        @(negedge clk);
        chk("reset_state", 64'(actual()), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i], i);
        end

        // Asynchronous reset while a write-back is in flight on line 7.
        step(1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (m_mode == 2 && (m_pix / W) == 7) found = 1'b1;
        end
        @(posedge clk);
        #2;
        chk("commit_wren", 64'(bus.buf_wren), 64'd1);
        chk("commit_row", 64'(bus.row), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'(actual()), 64'd0);
        m_mode = 0;
        m_pix  = 0;
        m_tog  = 1'b0;
        m_busy = 1'b0;
        m_ovr  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("idle_ready", 64'(bus.in_ready), 64'd0);
        end

        post = '{1, -1, 0, -1, 0, 0, 0, 96, 12, 1, 0};
        run_frame(post, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/blur_line_scheduler.md
Name: blur_line_scheduler

Overview:
Sequencer for the separable Gaussian blur line-buffer datapath. It paces incoming camera pixels into the two-phase blur pipeline: convolve, then write back to the M10K row buffers. It generates the column address shared by all row buffers, drives the write enable, and latches the 5x5/11x11 kernel select only at frame boundaries. It flags which blurred outputs are valid once the vertical and horizontal windows have filled.

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines per frame
ADDR_W, 13, width of row/col/address counters
H_LAT, 5, horizontal-convolution warm-up pixels per line before output is valid

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle start-of-frame pulse (vsync)
in_valid  in  1  camera pixel available
in_ready  out  1  scheduler accepts the pixel this cycle
kernel_sel  in  1  requested kernel: 0 = 5x5, 1 = 11x11
blur_toggle  out  1  kernel select presented to blur datapath, frame-stable
buf_addr  out  ADDR_W  column address shared by all line buffers
buf_wren  out  1  line-buffer write-back enable
row  out  ADDR_W  current line index
col  out  ADDR_W  current pixel index
out_valid  out  1  blurred pixel on datapath output is valid this cycle
frame_busy  out  1  frame in progress
frame_done  out  1  single-cycle end-of-frame pulse
overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including blur_toggle, counters, and overrun.
- States: IDLE, ACCEPT, COMMIT, DONE.
- IDLE:
  - in_ready=0, buf_wren=0.
  - On frame_start: blur_toggle<=kernel_sel, row<=0, col<=0, frame_busy<=1, go to ACCEPT.
- ACCEPT:
  - in_ready=1 combinationally while in this state.
  - Handshake is in_valid & in_ready. On handshake, go to COMMIT.
  - Without in_valid: stay in ACCEPT; buf_addr, row, and col hold; buf_wren=0.
- COMMIT (exactly one cycle):
  - in_ready=0, buf_wren=1, buf_addr=col.
  - out_valid=1 iff row >= K-1 and col >= H_LAT, where K=5 when blur_toggle=0 and K=11 when blur_toggle=1.
  - Counter update: col<=col+1. If col==WIDTH-1: col<=0 and row<=row+1.
  - If row==HEIGHT-1 and col==WIDTH-1: go to DONE. Otherwise go to ACCEPT.
- DONE (one cycle): frame_done=1, frame_busy<=0, counters reset to 0, go to IDLE.
- Throughput and latency:
  - Peak rate is 1 pixel per 2 clocks.
  - For a handshake at cycle t, buf_wren and out_valid (if qualified) occur at t+1.
  - Next earliest handshake is at t+2.
- buf_addr equals col at all times; it is not incremented until the COMMIT cycle ends.
- kernel_sel is ignored except on a frame_start that is acted upon. blur_toggle never changes mid-frame.
- frame_start while in ACCEPT/COMMIT/DONE:
  - overrun<=1.
  - Restart: row, col <= 0; blur_toggle<=kernel_sel; next state ACCEPT.
  - buf_wren/out_valid of an in-progress COMMIT are suppressed that cycle.
  - frame_done is not pulsed.
- frame_start coincident with DONE: treated as a restart. frame_done is suppressed and overrun is set.
- overrun clears only on reset.
- Widths: counters are ADDR_W bits. WIDTH and HEIGHT must be <= 2^ADDR_W. Comparisons are unsigned.

Test Plan:
- Common setup: WIDTH=8, HEIGHT=12, H_LAT=2.
1. Continuous in_valid, kernel_sel=0, frame_start -> 96 handshakes, 96 buf_wren pulses, 48 out_valid pulses (rows 4-11 x cols 2-7). frame_done occurs 1 cycle after the last COMMIT, and frame_busy falls with it.
2. Same stimulus with kernel_sel=1 -> 12 out_valid pulses (rows 10-11 x cols 2-7) and blur_toggle=1 for the whole frame.
3. in_valid low for 5 cycles at row=2, col=3 -> stays in ACCEPT with in_ready=1. buf_addr holds 3 and buf_wren=0; the stream resumes with no lost or duplicated pixels.
4. kernel_sel toggled 0->1 at row 6 -> blur_toggle stays 0 through frame_done, then becomes 1 on the next frame_start.
5. frame_start at row=3, col=5 -> overrun=1, row=col=0, no frame_done. The frame completes normally afterwards and overrun stays 1.
6. rst_n low mid-COMMIT at row=7 -> all outputs 0 immediately (async), state IDLE. in_ready stays 0 until the next frame_start.
